// File: rtl/mem_access_ctrl.sv
// Request sequencer in front of unified main memory; SUBWORD_EN adds byte-enable read-modify-write.
// Latency accept->rsp_valid: fetch/load 2, store 4 (5 with RMW), error 1.
// Backpressure: req_ready only in IDLE, so one request is outstanding at a time.
module mem_access_ctrl #(
  parameter int N         = 32,
  parameter int INST_NUM  = 50,
  parameter int DATA_BASE = 50,
  parameter int DEPTH     = 89
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_type,
  input  logic [N-1:0] req_adr,
  input  logic [N-1:0] req_wdata,
  input  logic [3:0]   req_be,
  output logic         rsp_valid,
  output logic [N-1:0] rsp_rdata,
  output logic         rsp_err,
  output logic [N-1:0] mem_adr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  output logic         mem_write,
  output logic         for_data_mem
);

  typedef enum logic [2:0] {IDLE, RD, WSET, WMRG, WPUL, WHLD, DONE, ERR} state_t;

  localparam logic [1:0] T_FETCH = 2'b00;
  localparam logic [1:0] T_LOAD  = 2'b01;
  localparam logic [1:0] T_STORE = 2'b10;

  state_t       state, next_state;
  logic [N-1:0] word_idx;
  logic         req_err;
  logic         accept;

  assign word_idx = {2'b00, req_adr[N-1:2]};
  assign accept   = req_valid && (state == IDLE);

  always_comb begin
    req_err = 1'b0;
    if (req_adr[1:0] != 2'b00) req_err = 1'b1;
    case (req_type)
      T_FETCH: if (word_idx >= N'(INST_NUM)) req_err = 1'b1;
      T_LOAD, T_STORE:
        if ((word_idx < N'(DATA_BASE)) || (word_idx >= N'(DEPTH))) req_err = 1'b1;
      default: req_err = 1'b1;
    endcase
  end

`ifdef SUBWORD_EN
  logic [3:0]   be_q;
  logic [N-1:0] wdata_q;
  logic [N-1:0] merged;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      be_q    <= 4'h0;
      wdata_q <= '0;
    end else if (accept) begin
      be_q    <= req_be;
      wdata_q <= req_wdata;
    end
  end

  // Enabled bytes come from the store data, the rest from the word read during WSET.
  always_comb begin
    merged = mem_rdata;
    for (int i = 0; i < 4; i++)
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
  end
`else
  logic unused_be;
  assign unused_be = ^req_be;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                  next_state = ERR;
          else if (req_type == T_STORE) next_state = WSET;
          else                          next_state = RD;
        end
      end
      RD:   next_state = DONE;
`ifdef SUBWORD_EN
      WSET: begin
        if (be_q == 4'h0)      next_state = DONE;
        else if (be_q != 4'hF) next_state = WMRG;
        else                   next_state = WPUL;
      end
`else
      WSET: next_state = WPUL;
`endif
      WMRG: next_state = WPUL;
      WPUL: next_state = WHLD;
      WHLD: next_state = DONE;
      DONE: next_state = IDLE;
      ERR:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= '0;
      mem_write    <= 1'b0;
      mem_adr      <= '0;
      mem_wdata    <= '0;
      for_data_mem <= 1'b0;
    end else begin
      req_ready <= (next_state == IDLE);
      rsp_valid <= (next_state == DONE) || (next_state == ERR);
      rsp_err   <= (next_state == ERR);
      mem_write <= (next_state == WPUL);
      if (accept && !req_err) begin
        for_data_mem <= (req_type != T_FETCH);
        mem_adr      <= (req_type == T_FETCH) ? req_adr : word_idx;
        if (req_type == T_STORE) mem_wdata <= req_wdata;
      end
      if (state == RD) rsp_rdata <= mem_rdata;
`ifdef SUBWORD_EN
      if ((state == WSET) && (be_q != 4'hF)) mem_wdata <= merged;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized + directed bench for mem_access_ctrl against a word-array reference model.
module tb_mem_access_ctrl;
  localparam int DEPTH = 89, INST_NUM = 50, DATA_BASE = 50;
`ifdef SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  logic        clk, rst, req_valid, req_ready, rsp_valid, rsp_err, mem_write, for_data_mem;
  logic [1:0]  req_type;
  logic [3:0]  req_be;
  logic [31:0] req_adr, req_wdata, rsp_rdata, mem_adr, mem_wdata, mem_rdata, rd_idx;
  logic [31:0] mem     [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];
  logic [31:0] last_rd;
  int n_checks = 0;
  int n_fail   = 0;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_adr(req_adr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_write(mem_write), .for_data_mem(for_data_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: combinational read, write on rising edge of mem_write.
  assign rd_idx    = for_data_mem ? mem_adr : (mem_adr >> 2);
  assign mem_rdata = (rd_idx < DEPTH) ? mem[rd_idx[6:0]] : 32'h0;
  always @(posedge mem_write) if (rd_idx < DEPTH) mem[rd_idx[6:0]] <= mem_wdata;

  function automatic bit exp_err(input logic [1:0] t, input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    if (a[1:0] != 2'b00 || t == 2'b11) return 1'b1;
    if (t == 2'b00) return (w >= INST_NUM);
    return (w < DATA_BASE) || (w >= DEPTH);
  endfunction

  // -1 = latency not pinned down (empty byte-enable store)
  function automatic int exp_lat(input logic [1:0] t, input logic [31:0] a, input logic [3:0] be);
    if (exp_err(t, a)) return 1;
    if (t != 2'b10) return 2;
    if (SUBWORD && be == 4'h0) return -1;
    if (SUBWORD && be != 4'hF) return 5;
    return 4;
  endfunction

  function automatic int exp_wcnt(input logic [1:0] t, input logic [31:0] a, input logic [3:0] be);
    if (exp_err(t, a) || t != 2'b10) return 0;
    if (SUBWORD && be == 4'h0) return 0;
    return 1;
  endfunction

  // Apply a request's effect to the reference memory; returns the expected rsp_rdata.
  task automatic model_apply(input logic [1:0] t, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] be, output logic [31:0] rd);
    logic [31:0] w;
    w = a >> 2;
    if (!exp_err(t, a)) begin
      if (t == 2'b10) begin
        for (int i = 0; i < 4; i++)
          if (!SUBWORD || be[i]) ref_mem[w][8*i +: 8] = wd[8*i +: 8];
      end else begin
        last_rd = ref_mem[w];
      end
    end
    rd = last_rd;
  endtask

  task automatic run_req(input logic [1:0] t, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output int lat, output logic err,
                         output logic [31:0] rd, output int wcnt, output int wpos,
                         output bit adr_ok, output bit rdy_after, output bit single,
                         output int waited);
    logic [31:0] eadr;
    logic        efdm;
    eadr = (t == 2'b00) ? a : (a >> 2);
    efdm = (t != 2'b00);
    lat = -1; err = 1'b0; rd = '0; wcnt = 0; wpos = -1;
    adr_ok = 1'b1; rdy_after = 1'b0; single = 1'b0; waited = 0;
    while (req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    req_valid = 1'b1; req_type = t; req_adr = a; req_wdata = wd; req_be = be;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_type = 2'($urandom); req_adr = $urandom;
    req_wdata = $urandom; req_be = 4'($urandom);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (mem_write === 1'b1) begin
        wcnt++;
        wpos = n;
      end
      if (rsp_valid === 1'b1) begin
        lat = n; err = rsp_err; rd = rsp_rdata;
        break;
      end
      if (mem_adr !== eadr || for_data_mem !== efdm) adr_ok = 1'b0;
    end
    @(negedge clk);
    rdy_after = (req_ready === 1'b1);
    single    = (rsp_valid === 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_err, mem_write, for_data_mem} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: rdy/vld/err/wr/fdm=%b expected 10000",
               {req_ready, rsp_valid, rsp_err, mem_write, for_data_mem});
    end
    n_checks++;
    if (rsp_rdata !== 32'h0 || mem_adr !== 32'h0 || mem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: rdata=%h adr=%h wdata=%h expected all 0", rsp_rdata, mem_adr, mem_wdata);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fetch;
    int lat, wc, wp, wt; logic err; logic [31:0] rd, m; bit ok, ra, sg;
    run_req(2'b00, 32'h8, 32'h0, 4'hF, lat, err, rd, wc, wp, ok, ra, sg, wt);
    model_apply(2'b00, 32'h8, 32'h0, 4'hF, m);
    n_checks++;
    if (lat !== 2 || err !== 1'b0 || rd !== 32'h00A00593 || wc !== 0 || !ok) begin
      n_fail++;
      $display("FAIL fetch_8: lat=%0d err=%b rd=%h wr=%0d adr_ok=%b expected 2/0/00a00593/0/1",
               lat, err, rd, wc, ok);
    end
  endtask

  task automatic test_load;
    int lat, wc, wp, wt; logic err; logic [31:0] rd, m; bit ok, ra, sg;
    run_req(2'b01, 32'd240, 32'h0, 4'hF, lat, err, rd, wc, wp, ok, ra, sg, wt);
    model_apply(2'b01, 32'd240, 32'h0, 4'hF, m);
    n_checks++;
    if (lat !== 2 || err !== 1'b0 || rd !== 32'hFFFFFFFB || wc !== 0 || !ok) begin
      n_fail++;
      $display("FAIL load_240: lat=%0d err=%b rd=%h wr=%0d adr_ok=%b expected 2/0/fffffffb/0/1",
               lat, err, rd, wc, ok);
    end
  endtask

  task automatic test_store_load;
    int lat, wc, wp, wt; logic err; logic [31:0] rd, m, prev; bit ok, ra, sg;
    prev = last_rd;
    run_req(2'b10, 32'd280, 32'h12345678, 4'hF, lat, err, rd, wc, wp, ok, ra, sg, wt);
    model_apply(2'b10, 32'd280, 32'h12345678, 4'hF, m);
    n_checks++;
    if (lat !== 4 || err !== 1'b0 || wc !== 1 || wp !== 2 || !ok || rd !== prev) begin
      n_fail++;
      $display("FAIL store_280: lat=%0d err=%b wr=%0d wpos=%0d adr_ok=%b rd=%h expected 4/0/1/2/1/%h",
               lat, err, wc, wp, ok, rd, prev);
    end
    run_req(2'b01, 32'd280, 32'h0, 4'hF, lat, err, rd, wc, wp, ok, ra, sg, wt);
    model_apply(2'b01, 32'd280, 32'h0, 4'hF, m);
    n_checks++;
    if (lat !== 2 || rd !== 32'h12345678) begin
      n_fail++;
      $display("FAIL reload_280: lat=%0d rd=%h expected 2/12345678", lat, rd);
    end
  endtask

  task automatic test_errors;
    logic [1:0]  t [8] = '{2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
    logic [31:0] a [8] = '{32'h10, 32'h102, 32'd200, 32'd196, 32'd200, 32'd196, 32'd352, 32'd356};
    int lat, wc, wp, wt; logic err; logic [31:0] rd, m; bit ok, ra, sg; bit ee;
    for (int i = 0; i < 8; i++) begin
      ee = exp_err(t[i], a[i]);
      run_req(t[i], a[i], 32'hDEADBEEF, 4'hF, lat, err, rd, wc, wp, ok, ra, sg, wt);
      model_apply(t[i], a[i], 32'hDEADBEEF, 4'hF, m);
      n_checks++;
      if (lat !== (ee ? 1 : 2) || err !== ee || wc !== 0 || !ra || !sg) begin
        n_fail++;
        $display("FAIL err_case%0d: lat=%0d err=%b wr=%0d rdy_next=%b single=%b expected %0d/%b/0/1/1",
                 i, lat, err, wc, ra, sg, ee ? 1 : 2, ee);
      end
      if (!ee) begin
        n_checks++;
        if (rd !== m) begin
          n_fail++;
          $display("FAIL bound_rd%0d: rd=%h expected %h", i, rd, m);
        end
      end
    end
  endtask

`ifdef SUBWORD_EN
  task automatic test_subword;
    int lat, wc, wp, wt; logic err; logic [31:0] rd, m; bit ok, ra, sg;
    run_req(2'b10, 32'd244, 32'hAABBCCDD, 4'b0010, lat, err, rd, wc, wp, ok, ra, sg, wt);
    model_apply(2'b10, 32'd244, 32'hAABBCCDD, 4'b0010, m);
    n_checks++;
    if (lat !== 5 || err !== 1'b0 || wc !== 1 || wp !== 3 || !ok) begin
      n_fail++;
      $display("FAIL rmw_store: lat=%0d err=%b wr=%0d wpos=%0d adr_ok=%b expected 5/0/1/3/1",
               lat, err, wc, wp, ok);
    end
    run_req(2'b01, 32'd244, 32'h0, 4'hF, lat, err, rd, wc, wp, ok, ra, sg, wt);
    model_apply(2'b01, 32'd244, 32'h0, 4'hF, m);
    n_checks++;
    if (rd !== 32'h0000CC08) begin
      n_fail++;
      $display("FAIL rmw_result: rd=%h expected 0000cc08", rd);
    end
    run_req(2'b10, 32'd244, 32'h11223344, 4'b0000, lat, err, rd, wc, wp, ok, ra, sg, wt);
    model_apply(2'b10, 32'd244, 32'h11223344, 4'b0000, m);
    n_checks++;
    if (lat < 1 || err !== 1'b0 || wc !== 0 || !ra) begin
      n_fail++;
      $display("FAIL be0_store: lat=%0d err=%b wr=%0d rdy_next=%b expected rsp/0/0/1", lat, err, wc, ra);
    end
  endtask
`endif

  task automatic test_back_to_back;
    logic [1:0]  t [3] = '{2'b01, 2'b10, 2'b00};
    logic [31:0] a [3] = '{32'd204, 32'd208, 32'd4};
    int lat, wc, wp, wt; logic err; logic [31:0] rd, m; bit ok, ra, sg;
    for (int i = 0; i < 3; i++) begin
      run_req(t[i], a[i], 32'hCAFE0000 + 32'(i), 4'hF, lat, err, rd, wc, wp, ok, ra, sg, wt);
      model_apply(t[i], a[i], 32'hCAFE0000 + 32'(i), 4'hF, m);
      n_checks++;
      if (wt !== 0 || lat !== exp_lat(t[i], a[i], 4'hF) || rd !== m) begin
        n_fail++;
        $display("FAIL b2b%0d: waited=%0d lat=%0d rd=%h expected 0/%0d/%h",
                 i, wt, lat, rd, exp_lat(t[i], a[i], 4'hF), m);
      end
    end
  endtask

  task automatic test_reset_midop;
    int guard, seen;
    req_valid = 1'b1; req_type = 2'b10; req_adr = 32'd300; req_wdata = 32'h5A5AA5A5; req_be = 4'hF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    guard = 0;
    while (mem_write !== 1'b1 && guard < 10) begin
      @(posedge clk);
      #2;
      guard++;
    end
    n_checks++;
    if (mem_write !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_pulse: mem_write=%b expected 1 within 10 cycles", mem_write);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (mem_write !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_abort: mem_write=%b req_ready=%b expected 0/1", mem_write, req_ready);
    end
    ref_mem[75] = 32'h5A5AA5A5;
    last_rd = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL midop_after: rsp_pulses=%0d req_ready=%b rdata=%h expected 0/1/0", seen, req_ready, rsp_rdata);
    end
  endtask

  task automatic test_random;
    int lat, wc, wp, wt, e_lat, e_wc; logic err, e_err; logic [31:0] rd, e_rd, a, wd;
    logic [1:0] t; logic [3:0] be; bit ok, ra, sg;
    for (int i = 0; i < 60; i++) begin
      t  = 2'($urandom_range(0, 3));
      wd = $urandom;
      be = (($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom));
      case ($urandom_range(0, 4))
        0: a = 32'($urandom_range(0, 49)) * 4;
        1: a = 32'($urandom_range(50, 88)) * 4;
        2: a = 32'($urandom_range(89, 200)) * 4;
        3: a = 32'($urandom_range(0, 88)) * 4 + 32'($urandom_range(1, 3));
        default: a = $urandom;
      endcase
      e_err = exp_err(t, a);
      e_lat = exp_lat(t, a, be);
      e_wc  = exp_wcnt(t, a, be);
      run_req(t, a, wd, be, lat, err, rd, wc, wp, ok, ra, sg, wt);
      model_apply(t, a, wd, be, e_rd);
      n_checks++;
      if (err !== e_err || (e_lat >= 0 && lat !== e_lat) || lat < 0 || wc !== e_wc || !ra || !sg) begin
        n_fail++;
        $display("FAIL rand%0d t=%0d a=%h be=%h: lat=%0d err=%b wr=%0d rdy=%b single=%b expected %0d/%b/%0d/1/1",
                 i, t, a, be, lat, err, wc, ra, sg, e_lat, e_err, e_wc);
      end
      if (!e_err) begin
        n_checks++;
        if (rd !== e_rd || !ok || (e_wc == 1 && wp !== e_lat - 2)) begin
          n_fail++;
          $display("FAIL rand%0d_data: rd=%h adr_ok=%b wpos=%0d expected %h/1/%0d",
                   i, rd, ok, wp, e_rd, e_lat - 2);
        end
      end
    end
  endtask

  task automatic test_mem_image;
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL mem_image: %0d words differ, expected 0", bad);
    end
  endtask

  initial begin
    req_valid = 1'b0; req_type = 2'b00; req_adr = '0; req_wdata = '0; req_be = 4'h0;
    last_rd = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[2]  = 32'h00A00593;
    mem[60] = 32'hFFFFFFFB;
    mem[61] = 32'h00000008;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem[i];
    test_reset;
    test_fetch;
    test_load;
    test_store_load;
    test_errors;
`ifdef SUBWORD_EN
    test_subword;
`endif
    test_back_to_back;
    test_reset_midop;
    test_random;
    test_mem_image;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
